// File: rtl/router_input_buffer_if.sv
// Router input buffer port bundle: upstream link plus arbiter/crossbar side.
// slave = the buffer, master = whoever drives the link and the grant.
interface router_input_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  full;
  logic                  grant;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic [2:0]            flit_id;
  logic [11:0]           length;
  logic                  req;
  logic                  empty;
  logic                  err;

  modport slave (
    input  data_in, wr_en, grant, rd_en,
    output full, data_out, flit_id,
    output length, req, empty, err
  );

  modport master (
    output data_in, wr_en, grant, rd_en,
    input  full, data_out, flit_id,
    input  length, req, empty, err
  );
endinterface

// File: rtl/router_input_buffer.sv
// Per-port NoC router input stage: flit FIFO, head decode and
// request/route FSM in front of the arbiter.
module router_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input logic clk,
  input logic rst,
  router_input_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ROUTE
  } state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [11:0]           len_reg;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            head_id;
  logic empty;
  logic full;
  logic is_hdr;
  logic is_tail;
  logic wr_ok;
  logic pop;
  logic drop;
  logic load_len;

  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign head_id = head[DATA_WIDTH-1 -: 3];
  assign is_hdr  = !empty && (head_id == 3'b001);
  assign is_tail = (head_id == 3'b100);

  // full blocks the write even if a pop frees a slot this cycle
  assign wr_ok = bus.wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drop      = 1'b0;
    load_len  = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_hdr) begin
          state_nxt = REQ;
          load_len  = 1'b1;
        end else if (!empty) begin
          pop  = 1'b1;
          drop = 1'b1;
        end
      end
      REQ: begin
        if (bus.grant) state_nxt = ROUTE;
      end
      ROUTE: begin
        if (!bus.grant) begin
          state_nxt = REQ;
        end else if (bus.rd_en && !empty) begin
          pop = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_reg <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= drop;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (load_len) len_reg <= head[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.data_out = head;
  assign bus.flit_id  = empty ? 3'b000 : head_id;
  assign bus.length   = is_hdr ? head[11:0] : len_reg;
  assign bus.req      = (state != IDLE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: vector table, directed corner
// sequences and random packets against a queue-based model.
module tb_router_input_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_input_buffer_if #(.DATA_WIDTH(DW)) bus ();

  router_input_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // model: buffered flits, packet phase (0 idle, 1 requesting,
  // 2 routing), latched length and last drop flag
  logic [31:0] mq[$];
  int          mphase = 0;
  logic [11:0] mlen = '0;
  logic        merr = 1'b0;

  typedef struct packed {
    logic        r;
    logic        w;
    logic        g;
    logic        rd;
    logic [31:0] d;
    logic        e;
    logic        f;
    logic        req;
    logic [2:0]  fid;
    logic [11:0] len;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] fid_of(input logic [31:0] f);
    return f[31:29];
  endfunction

  task automatic model_edge(input logic r, input logic w,
                            input logic [31:0] d,
                            input logic g, input logic rd);
    logic had;
    logic pop;
    logic drop;
    logic wr;
    logic [31:0] h;
    if (r) begin
      mq.delete();
      mphase = 0;
      mlen = '0;
      merr = 1'b0;
      return;
    end
    had = (mq.size() > 0);
    h = had ? mq[0] : '0;
    drop = (mphase == 0) && had && (fid_of(h) != 3'b001);
    pop = drop || ((mphase == 2) && g && rd && had);
    wr = w && (mq.size() < DEPTH);
    merr = drop;
    case (mphase)
      0: if (had && fid_of(h) == 3'b001) begin
           mphase = 1;
           mlen = h[11:0];
         end
      1: if (g) mphase = 2;
      default: begin
        if (!g) mphase = 1;
        else if (pop && fid_of(h) == 3'b100) mphase = 0;
      end
    endcase
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back(d);
  endtask

  task automatic check_model();
    logic e;
    logic [2:0] fid;
    logic [11:0] len;
    e = (mq.size() == 0);
    fid = e ? 3'b000 : fid_of(mq[0]);
    len = (!e && fid == 3'b001) ? mq[0][11:0] : mlen;
    chk("m_empty", 32'(bus.empty), 32'(e));
    chk("m_full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("m_req", 32'(bus.req), 32'(mphase != 0));
    chk("m_flit_id", 32'(bus.flit_id), 32'(fid));
    chk("m_length", 32'(bus.length), 32'(len));
    chk("m_err", 32'(bus.err), 32'(merr));
    if (!e) chk("m_data_out", bus.data_out, mq[0]);
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [31:0] d,
                      input logic g, input logic rd);
    rst = r;
    bus.wr_en = w;
    bus.data_in = d;
    bus.grant = g;
    bus.rd_en = rd;
    @(posedge clk);
    model_edge(r, w, d, g, rd);
    @(negedge clk);
    check_model();
  endtask

  function automatic vec_t mk(
    input logic r, input logic w, input logic [31:0] d,
    input logic g, input logic rd,
    input logic e, input logic f, input logic req,
    input logic [2:0] fid, input logic [11:0] len,
    input logic [31:0] dout);
    vec_t v;
    v.r = r; v.w = w; v.d = d; v.g = g; v.rd = rd;
    v.e = e; v.f = f; v.req = req;
    v.fid = fid; v.len = len; v.dout = dout;
    return v;
  endfunction

  localparam logic [31:0] H5 = 32'h2000_0005;
  localparam logic [31:0] H3 = 32'h2000_0003;
  localparam logic [31:0] H4 = 32'h2000_0004;
  localparam logic [31:0] H2 = 32'h2000_0002;
  localparam logic [31:0] BB = 32'h4000_0011;
  localparam logic [31:0] TT = 32'h8000_0022;
  localparam logic [31:0] BE = 32'h4000_0000;

  initial begin
    int n;
    int errs;
    int reqs;
    logic [31:0] pq[$];
    bus.wr_en = 1'b0;
    bus.data_in = '0;
    bus.grant = 1'b0;
    bus.rd_en = 1'b0;

    tbl[0]  = mk(1,0,0, 0,0, 1,0,0, 3'd0, 12'd0, 0);
    tbl[1]  = mk(0,1,H5,0,0, 0,0,0, 3'd1, 12'd5, H5);
    tbl[2]  = mk(0,1,H5,0,0, 0,0,1, 3'd1, 12'd5, H5);
    tbl[3]  = mk(0,1,H5,0,0, 0,0,1, 3'd1, 12'd5, H5);
    tbl[4]  = mk(0,1,H5,0,0, 0,1,1, 3'd1, 12'd5, H5);
    tbl[5]  = mk(0,1,H3,0,0, 0,1,1, 3'd1, 12'd5, H5);
    tbl[6]  = mk(1,0,0, 0,0, 1,0,0, 3'd0, 12'd0, 0);
    tbl[7]  = mk(0,1,H3,0,0, 0,0,0, 3'd1, 12'd3, H3);
    tbl[8]  = mk(0,1,BB,1,1, 0,0,1, 3'd1, 12'd3, H3);
    tbl[9]  = mk(0,1,TT,1,1, 0,0,1, 3'd1, 12'd3, H3);
    tbl[10] = mk(0,0,0, 1,1, 0,0,1, 3'd2, 12'd3, BB);
    tbl[11] = mk(0,0,0, 1,1, 0,0,1, 3'd4, 12'd3, TT);
    tbl[12] = mk(0,0,0, 1,1, 1,0,0, 3'd0, 12'd3, 0);

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].g, tbl[i].rd);
      chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_req", i), 32'(bus.req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_fid", i), 32'(bus.flit_id), 32'(tbl[i].fid));
      chk($sformatf("tbl%0d_len", i), 32'(bus.length), 32'(tbl[i].len));
      chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'd0);
      if (!tbl[i].e)
        chk($sformatf("tbl%0d_dout", i), bus.data_out, tbl[i].dout);
    end

    // grant withdrawn mid-packet
    step(1,0,0,0,0);
    step(0,1,H3,0,0);
    step(0,1,BB,0,0);
    step(0,1,TT,0,0);
    step(0,0,0,1,1);
    step(0,0,0,1,1);
    step(0,0,0,0,1);
    chk("ungrant_req", 32'(bus.req), 32'd1);
    chk("ungrant_fid", 32'(bus.flit_id), 32'd2);
    chk("ungrant_len", 32'(bus.length), 32'd3);
    step(0,0,0,0,1);
    chk("ungrant_hold", bus.data_out, BB);
    step(0,0,0,1,1);
    step(0,0,0,1,1);
    step(0,0,0,1,1);
    chk("regrant_empty", 32'(bus.empty), 32'd1);
    chk("regrant_req", 32'(bus.req), 32'd0);

    // stray body flit in IDLE
    step(1,0,0,0,0);
    errs = 0;
    reqs = 0;
    step(0,1,BE,1,1);
    for (int i = 0; i < 4; i++) begin
      step(0,0,0,1,1);
      if (bus.err) errs++;
      if (bus.req) reqs++;
    end
    chk("drop_err_cycles", 32'(errs), 32'd1);
    chk("drop_req", 32'(reqs), 32'd0);
    chk("drop_empty", 32'(bus.empty), 32'd1);

    // full buffer with write and pop together
    step(1,0,0,0,0);
    step(0,1,H4,0,0);
    step(0,1,BB,0,0);
    step(0,1,BB,0,0);
    step(0,1,TT,0,0);
    chk("fill_full", 32'(bus.full), 32'd1);
    step(0,1,H2,1,1);
    chk("full_drop", 32'(bus.full), 32'd1);
    step(0,1,H2,1,1);
    chk("full_pop_full", 32'(bus.full), 32'd0);
    n = 0;
    while (!bus.empty && n < 10) begin
      step(0,0,0,1,1);
      n++;
    end
    chk("full_pop_drain", 32'(n), 32'd3);

    // streaming through pointer wrap
    for (int i = 0; i < 20; i++)
      step(0,1,(i % 2 == 0) ? H2 : TT,1,1);
    n = 0;
    while (!bus.empty && n < 20) begin
      step(0,0,0,1,1);
      n++;
    end
    chk("stream_drained", 32'(bus.empty), 32'd1);

    // reset in the middle of a routed packet
    step(0,1,H3,0,0);
    step(0,1,BB,0,0);
    step(0,1,TT,0,0);
    step(0,0,0,1,1);
    step(0,0,0,1,1);
    step(1,0,0,1,1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_fid", 32'(bus.flit_id), 32'd0);
    chk("rst_len", 32'(bus.length), 32'd0);
    step(0,1,H5,0,0);
    step(0,0,0,0,0);
    chk("rst_new_req", 32'(bus.req), 32'd1);

    // random packets
    for (int c = 0; c < 800; c++) begin
      logic r, w, g, rd, acc;
      logic [31:0] d;
      if (pq.size() == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          d = $urandom;
          d[31:29] = 3'b010;
          pq.push_back(d);
        end else begin
          d = $urandom;
          d[31:29] = 3'b001;
          pq.push_back(d);
          n = $urandom_range(0, 3);
          for (int b = 0; b < n; b++) begin
            d = $urandom;
            d[31:29] = ($urandom_range(0, 3) == 0) ? 3'b011 : 3'b010;
            pq.push_back(d);
          end
          d = $urandom;
          d[31:29] = 3'b100;
          pq.push_back(d);
        end
      end
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 9) < 7);
      g = ($urandom_range(0, 9) < 8);
      rd = ($urandom_range(0, 9) < 7);
      d = w ? pq[0] : $urandom;
      acc = w && !r && (mq.size() < DEPTH);
      step(r, w, d, g, rd);
      if (r) pq.delete();
      else if (acc) void'(pq.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
